// File: rtl/pattern_lut_loader_pkg.sv
// Shared constants and state encoding for the pattern-finder LUT loader.
package pattern_lut_loader_pkg;
  localparam int LUT_MXADRB = 11;
  localparam int LUT_MXDATB = 9;
  localparam int LUT_CKSUMW = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_FILL    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_CAP  = 3'd4
  } lut_state_e;
endpackage

// File: rtl/pattern_lut_loader_addr_ptr.sv
// Loadable, wrapping, auto-increment LUT address counter; also drives the fill sweep.
module lut_addr_ptr
  import pattern_lut_loader_pkg::*;
#(
  parameter int W = LUT_MXADRB
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Increment applies after the load, so a load+inc lands on ld_val+1; wrap is the natural W-bit overflow.
  always_comb begin
    ptr_d = (ld_i ? ld_val_i : ptr_q) + {{(W-1){1'b0}}, inc_i};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/pattern_lut_loader.sv
// Host-side writer for the pattern-finder LUT (RAM port 0): single/burst writes, fill, readback.
// Define LUT_CHECKSUM_EN to build the running 16-bit checksum of written data; otherwise checksum is 0.
module pattern_lut_loader
  import pattern_lut_loader_pkg::*;
#(
  parameter int MXADRB    = LUT_MXADRB,
  parameter int MXDATB    = LUT_MXDATB,
  parameter int ROMLENGTH = 1 << MXADRB
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic                  host_fill,
  input  logic                  host_adr_ld,
  input  logic [MXADRB-1:0]     host_adr,
  input  logic [MXDATB-1:0]     host_dat,
  input  logic                  host_auto_inc,
  output logic [MXDATB-1:0]     host_rd_dat,
  output logic                  host_rd_vld,
  output logic                  busy,
  output logic                  done,
  output logic                  err_busy,
  output logic [MXADRB-1:0]     adr_ptr,
  output logic                  ram_we,
  output logic [MXADRB-1:0]     ram_adr,
  output logic [MXDATB-1:0]     ram_din,
  input  logic [MXDATB-1:0]     ram_dout,
  output logic [LUT_CKSUMW-1:0] checksum
);
  localparam logic [MXADRB-1:0] LAST_ADR = MXADRB'(ROMLENGTH - 1);

  lut_state_e        state_q;
  logic              ram_we_q, busy_q, done_q, rd_vld_q, err_q, rd_inc_q;
  logic [MXADRB-1:0] ram_adr_q;
  logic [MXDATB-1:0] ram_din_q, rd_dat_q;

  logic              accept, do_fill, do_wr, do_rd, collide;
  logic [MXADRB-1:0] sel_adr;
  logic              ptr_ld, ptr_inc;
  logic [MXADRB-1:0] ptr_val;

  lut_addr_ptr #(.W(MXADRB)) u_ptr (
    .clock    (clock),
    .reset    (reset),
    .ld_i     (ptr_ld),
    .ld_val_i (ptr_val),
    .inc_i    (ptr_inc),
    .ptr_o    (adr_ptr)
  );

  always_comb begin
    // WRITE is not a busy state, so back-to-back strobes are taken there just as in IDLE.
    accept  = (state_q == ST_IDLE) || (state_q == ST_WRITE);
    do_fill = accept && host_fill;
    do_wr   = accept && host_wr && !host_fill;
    do_rd   = accept && host_rd && !host_fill && !host_wr;
    collide = accept ? ((host_fill && (host_wr || host_rd)) || (host_wr && host_rd))
                     : (host_fill || host_wr || host_rd);
    sel_adr = host_adr_ld ? host_adr : adr_ptr;
    ptr_ld  = 1'b0;
    ptr_val = host_adr;
    ptr_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (do_fill) begin
          ptr_ld  = 1'b1;
          ptr_val = '0;
          ptr_inc = 1'b1;
        end else begin
          ptr_ld  = host_adr_ld;
          ptr_inc = do_wr && host_auto_inc;
        end
      end
      ST_FILL: begin
        if (ram_adr_q == LAST_ADR) begin
          ptr_ld  = 1'b1;
          ptr_val = '0;
        end else begin
          ptr_inc = 1'b1;
        end
      end
      ST_RD_CAP: ptr_inc = rd_inc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ram_we_q  <= 1'b0;
      ram_adr_q <= '0;
      ram_din_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
      err_q     <= 1'b0;
      rd_inc_q  <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      if (collide) err_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (do_fill) begin
            state_q   <= ST_FILL;
            ram_we_q  <= 1'b1;
            ram_adr_q <= '0;
            ram_din_q <= host_dat;
            busy_q    <= 1'b1;
          end else if (do_wr) begin
            state_q   <= ST_WRITE;
            ram_we_q  <= 1'b1;
            ram_adr_q <= sel_adr;
            ram_din_q <= host_dat;
          end else if (do_rd) begin
            state_q   <= ST_RD_WAIT;
            ram_adr_q <= sel_adr;
            busy_q    <= 1'b1;
            rd_inc_q  <= host_auto_inc;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (ram_adr_q == LAST_ADR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ram_we_q  <= 1'b1;
            ram_adr_q <= adr_ptr;
          end
        end
        ST_RD_WAIT: state_q <= ST_RD_CAP;
        ST_RD_CAP: begin
          state_q  <= ST_IDLE;
          rd_dat_q <= ram_dout;
          rd_vld_q <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LUT_CHECKSUM_EN
  logic [LUT_CKSUMW-1:0] checksum_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         checksum_q <= '0;
    else if (do_fill)  checksum_q <= '0;
    else if (ram_we_q) checksum_q <= checksum_q + LUT_CKSUMW'(ram_din_q);
  end
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign ram_we      = ram_we_q;
  assign ram_adr     = ram_adr_q;
  assign ram_din     = ram_din_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign host_rd_vld = rd_vld_q;
  assign host_rd_dat = rd_dat_q;
  assign err_busy    = err_q;
endmodule
